// File: rtl/div_bus_master.sv
// Host-side sequencer for the byte-serial divider: sends A/Q/M operand bytes, waits for done, captures R then Q.
// Optional macro DIV_BUS_MASTER_OVERFLOW_CHECK_EN rejects |A| >= |M| with err=11 before any divider traffic.
module div_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TMO_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_dividend,
    input  logic [7:0]  req_divisor,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_quotient,
    output logic [7:0]  rsp_remainder,
    output logic [1:0]  rsp_err,
    output logic        div_enable,
    output logic [7:0]  div_inbus,
    input  logic        div_done,
    input  logic [7:0]  div_outbus
);

    typedef enum logic [2:0] {
        IDLE, SEND_A, SEND_Q, SEND_M, WAIT, CAP_R, CAP_Q, RESP
    } state_t;

    // Counter starts at 0 in the first WAIT cycle, so expiry at TIMEOUT_CYCLES-2 puts RESP
    // exactly TIMEOUT_CYCLES cycles after SEND_M.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 2);

    state_t           state_q, state_d;
    logic [7:0]       a_q, a_d, qb_q, qb_d, m_q, m_d;
    logic [7:0]       rem_q, rem_d, quo_q, quo_d;
    logic [1:0]       err_q, err_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             ovf;

`ifdef DIV_BUS_MASTER_OVERFLOW_CHECK_EN
    logic [8:0] mag_a, mag_m;
    always_comb begin
        mag_a = req_dividend[15] ? (9'd256 - {1'b0, req_dividend[15:8]}) : {1'b0, req_dividend[15:8]};
        mag_m = req_divisor[7]   ? (9'd256 - {1'b0, req_divisor})        : {1'b0, req_divisor};
        ovf   = (mag_a >= mag_m);
    end
`else
    assign ovf = 1'b0;
`endif

    assign req_ready     = (state_q == IDLE);
    assign rsp_valid     = (state_q == RESP);
    assign div_enable    = (state_q == SEND_A);
    assign rsp_quotient  = quo_q;
    assign rsp_remainder = rem_q;
    assign rsp_err       = err_q;

    always_comb begin
        div_inbus = '0;
        case (state_q)
            SEND_A:  div_inbus = a_q;
            SEND_Q:  div_inbus = qb_q;
            SEND_M:  div_inbus = m_q;
            default: div_inbus = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        qb_d    = qb_q;
        m_d     = m_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d   = req_dividend[15:8];
                    qb_d  = req_dividend[7:0];
                    m_d   = req_divisor;
                    rem_d = '0;
                    quo_d = '0;
                    if (req_divisor == 8'h00) begin
                        err_d   = 2'b01;
                        state_d = RESP;
                    end else if (ovf) begin
                        err_d   = 2'b11;
                        state_d = RESP;
                    end else begin
                        err_d   = 2'b00;
                        state_d = SEND_A;
                    end
                end
            end
            SEND_A: state_d = SEND_Q;
            SEND_Q: state_d = SEND_M;
            SEND_M: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (div_done) begin
                    state_d = CAP_R;
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = 2'b10;
                    state_d = RESP;
                end
            end
            CAP_R: begin
                rem_d   = div_outbus;
                state_d = CAP_Q;
            end
            CAP_Q: begin
                quo_d   = div_outbus;
                err_d   = 2'b00;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            qb_q    <= '0;
            m_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            qb_q    <= qb_d;
            m_q     <= m_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_div_bus_master.sv
// Randomized self-checking bench for div_bus_master; a bench-side divider model answers with chosen bytes.
module tb_div_bus_master;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_dividend;
    logic [7:0]  req_divisor;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_quotient;
    logic [7:0]  rsp_remainder;
    logic [1:0]  rsp_err;
    logic        div_enable;
    logic [7:0]  div_inbus;
    logic        div_done;
    logic [7:0]  div_outbus;

    int n_checks = 0;
    int n_errors = 0;

    div_bus_master #(.TIMEOUT_CYCLES(T), .TMO_W(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_err(rsp_err),
        .div_enable(div_enable), .div_inbus(div_inbus),
        .div_done(div_done), .div_outbus(div_outbus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected error code from the request rules; delay==0 means the divider never answers.
    function automatic logic [1:0] exp_err(input logic [15:0] dvd, input logic [7:0] dvs, input int delay);
`ifdef DIV_BUS_MASTER_OVERFLOW_CHECK_EN
        int a;
        int m;
`endif
        if (dvs == 8'h00) return 2'b01;
`ifdef DIV_BUS_MASTER_OVERFLOW_CHECK_EN
        a = $signed(dvd[15:8]);
        m = $signed(dvs);
        if (a < 0) a = -a;
        if (m < 0) m = -m;
        if (a >= m) return 2'b11;
`else
        if (dvd == 16'hFFFF && dvs == 8'hFF) return 2'b00;
`endif
        if (delay == 0) return 2'b10;
        return 2'b00;
    endfunction

    task automatic check_rsp(input logic [1:0] e, input logic [7:0] er, input logic [7:0] eq);
        check("rsp_valid", 16'(rsp_valid), 16'd1);
        check("rsp_err", 16'(rsp_err), 16'(e));
        check("rsp_rem", 16'(rsp_remainder), 16'(er));
        check("rsp_quo", 16'(rsp_quotient), 16'(eq));
        check("req_ready_busy", 16'(req_ready), 16'd0);
    endtask

    task automatic do_txn(input logic [15:0] dvd, input logic [7:0] dvs, input int delay,
                          input int hold, input logic [7:0] rem, input logic [7:0] quo);
        logic [1:0] e;
        logic [7:0] er;
        logic [7:0] eq;
        e  = exp_err(dvd, dvs, delay);
        er = 8'h00;
        eq = 8'h00;
        @(negedge clk);
        check("req_ready_idle", 16'(req_ready), 16'd1);
        req_valid    = 1'b1;
        req_dividend = dvd;
        req_divisor  = dvs;
        @(negedge clk);
        req_valid    = 1'b0;
        req_dividend = 16'($urandom);
        req_divisor  = 8'($urandom);
        if (e == 2'b01 || e == 2'b11) begin
            check("no_div_enable", 16'(div_enable), 16'd0);
        end else begin
            check("send_a_en", 16'(div_enable), 16'd1);
            check("send_a_bus", 16'(div_inbus), 16'(dvd[15:8]));
            @(negedge clk);
            check("send_q_en", 16'(div_enable), 16'd0);
            check("send_q_bus", 16'(div_inbus), 16'(dvd[7:0]));
            @(negedge clk);
            check("send_m_en", 16'(div_enable), 16'd0);
            check("send_m_bus", 16'(div_inbus), 16'(dvs));
            if (delay == 0) begin
                for (int k = 1; k < T; k++) begin
                    @(negedge clk);
                    check("tmo_wait_valid", 16'(rsp_valid), 16'd0);
                    check("wait_bus", 16'(div_inbus), 16'd0);
                end
                @(negedge clk);
            end else begin
                for (int k = 1; k <= delay; k++) begin
                    @(negedge clk);
                    check("wait_valid", 16'(rsp_valid), 16'd0);
                    check("wait_bus", 16'(div_inbus), 16'd0);
                    div_done = (k == delay);
                end
                @(negedge clk);
                div_done   = 1'b0;
                div_outbus = rem;
                @(negedge clk);
                div_outbus = quo;
                @(negedge clk);
                div_outbus = 8'($urandom);
                er = rem;
                eq = quo;
            end
        end
        for (int i = 0; i < hold; i++) begin
            check_rsp(e, er, eq);
            div_done = 1'($urandom);
            @(negedge clk);
        end
        div_done = 1'b0;
        check_rsp(e, er, eq);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 16'(rsp_valid), 16'd0);
        check("req_ready_back", 16'(req_ready), 16'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_dividend = '0;
        req_divisor  = '0;
        rsp_ready    = 1'b0;
        div_done     = 1'b0;
        div_outbus   = '0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 16'(req_ready), 16'd1);
        check("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        check("rst_err", 16'(rsp_err), 16'd0);
        check("rst_quo", 16'(rsp_quotient), 16'd0);
        check("rst_rem", 16'(rsp_remainder), 16'd0);
        check("rst_div_en", 16'(div_enable), 16'd0);
        check("rst_inbus", 16'(div_inbus), 16'd0);
        rst = 1'b0;

        do_txn(16'h0007, 8'h03, 2, 0, 8'h01, 8'h02);
        do_txn(16'h1234, 8'h00, 3, 0, 8'h55, 8'h66);
        do_txn(16'h0007, 8'h03, 0, 0, 8'hAA, 8'hBB);
        do_txn(16'h0040, 8'h07, 4, 5, 8'h03, 8'h09);
        do_txn(16'h0021, 8'h05, T - 1, 1, 8'h02, 8'h06);
        do_txn(16'h0500, 8'h03, 2, 0, 8'h01, 8'h02);
        do_txn(16'h80FF, 8'h7F, 3, 0, 8'h11, 8'h22);

        // Reset while waiting on the divider; a late done must not wake the master.
        @(negedge clk);
        req_valid    = 1'b1;
        req_dividend = 16'h0100;
        req_divisor  = 8'h05;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        div_done = 1'b1;
        @(negedge clk);
        div_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("post_rst_valid", 16'(rsp_valid), 16'd0);
            check("post_rst_ready", 16'(req_ready), 16'd1);
            check("post_rst_en", 16'(div_enable), 16'd0);
            @(negedge clk);
        end
        do_txn(16'h0010, 8'h04, 3, 2, 8'h00, 8'h04);

        for (int n = 0; n < 30; n++) begin
            logic [15:0] dvd;
            logic [7:0]  dvs;
            dvd = 16'($urandom);
            dvs = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            do_txn(dvd, dvs, int'($urandom_range(0, T - 1)), int'($urandom_range(0, 3)),
                   8'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
